// File: rtl/mem_port_sequencer_if.sv
// Memory-side request/ack bus shared by the sequencer and the memory model.
// The master issues requests; the slave answers with ack and read data.
interface mem_port_sequencer_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/mem_port_sequencer.sv
// Shares one single-ported memory between instruction fetch and load/store,
// releasing the core for one commit cycle per instruction.
module mem_port_sequencer #(
    parameter int unsigned TIMEOUT   = 255,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr_addr,
    input  logic [31:0] data_addr,
    input  logic        should_read_mem,
    input  logic        should_write_mem,
    input  logic [31:0] mem_write_data,
    output logic [31:0] instr,
    output logic [31:0] mem_read_data,
    output logic        core_stall,
    output logic        bus_err,
    output logic [31:0] instret,
    mem_port_sequencer_if.master mem
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_DATA,
        ST_COMMIT,
        ST_HALT
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] rdata_q, rdata_d;
    logic        is_write_q, is_write_d;
    logic        bus_err_q, bus_err_d;
    logic [31:0] instret_q, instret_d;
    logic [CW-1:0] wait_q, wait_d;

    logic        req_c;
    logic        we_c;
    logic [31:0] addr_c;
    logic        stall_c;
    logic        timeout_hit;

    // Ack wins over an expiring counter in the same cycle.
    assign timeout_hit = (TIMEOUT != 0)
                       && (wait_q == WAIT_LAST)
                       && !mem.mem_ack;

    always_comb begin
        state_d    = state_q;
        instr_d    = instr_q;
        rdata_d    = rdata_q;
        is_write_d = is_write_q;
        bus_err_d  = bus_err_q;
        instret_d  = instret_q;
        wait_d     = wait_q;
        req_c      = 1'b0;
        we_c       = 1'b0;
        addr_c     = instr_addr;
        stall_c    = 1'b1;

        unique case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
                wait_d  = '0;
            end
            ST_FETCH: begin
                req_c  = 1'b1;
                addr_c = instr_addr;
                if (mem.mem_ack) begin
                    instr_d = mem.mem_rdata;
                    wait_d  = '0;
                    state_d = ST_DECODE;
                end else if (timeout_hit) begin
                    bus_err_d = 1'b1;
                    instr_d   = NOP_INSTR;
                    state_d   = ST_HALT;
                end else begin
                    wait_d = wait_q + CW'(1);
                end
            end
            ST_DECODE: begin
                wait_d = '0;
                if (should_write_mem) begin
                    is_write_d = 1'b1;
                    state_d    = ST_DATA;
                    // Conflicting decode: store wins, flag the fault.
                    if (should_read_mem) begin
                        bus_err_d = 1'b1;
                    end
                end else if (should_read_mem) begin
                    is_write_d = 1'b0;
                    state_d    = ST_DATA;
                end else begin
                    state_d = ST_COMMIT;
                end
            end
            ST_DATA: begin
                req_c  = 1'b1;
                we_c   = is_write_q;
                addr_c = data_addr;
                if (mem.mem_ack) begin
                    if (!is_write_q) begin
                        rdata_d = mem.mem_rdata;
                    end
                    wait_d  = '0;
                    state_d = ST_COMMIT;
                end else if (timeout_hit) begin
                    bus_err_d = 1'b1;
                    instr_d   = NOP_INSTR;
                    state_d   = ST_HALT;
                end else begin
                    wait_d = wait_q + CW'(1);
                end
            end
            ST_COMMIT: begin
                stall_c   = 1'b0;
                instret_d = instret_q + 32'd1;
                wait_d    = '0;
                state_d   = ST_FETCH;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_HALT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            instr_q    <= NOP_INSTR;
            rdata_q    <= '0;
            is_write_q <= 1'b0;
            bus_err_q  <= 1'b0;
            instret_q  <= '0;
            wait_q     <= '0;
        end else begin
            state_q    <= state_d;
            instr_q    <= instr_d;
            rdata_q    <= rdata_d;
            is_write_q <= is_write_d;
            bus_err_q  <= bus_err_d;
            instret_q  <= instret_d;
            wait_q     <= wait_d;
        end
    end

    assign mem.mem_req   = req_c;
    assign mem.mem_we    = we_c;
    assign mem.mem_addr  = addr_c;
    assign mem.mem_wdata = mem_write_data;

    assign instr         = instr_q;
    assign mem_read_data = rdata_q;
    assign core_stall    = stall_c;
    assign bus_err       = bus_err_q;
    assign instret       = instret_q;

endmodule

// File: tb/tb_mem_port_sequencer.sv
// Directed bench for mem_port_sequencer with a small ack-delay memory model.
// Timeout is shortened to 4 so the trap path is reachable quickly.
module tb_mem_port_sequencer;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] ALU = 32'h0050_0093;
    localparam logic [31:0] LW  = 32'h0001_2083;
    localparam logic [31:0] SW  = 32'h0011_2023;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [31:0] instr_addr = 32'h10;
    logic [31:0] data_addr = 32'h100;
    logic        should_read_mem = 1'b0;
    logic        should_write_mem = 1'b0;
    logic [31:0] mem_write_data = 32'h0;
    logic [31:0] instr, mem_read_data, instret;
    logic        core_stall, bus_err;

    mem_port_sequencer_if mif();

    mem_port_sequencer #(.TIMEOUT(4), .NOP_INSTR(NOP)) dut (
        .clk              (clk),
        .reset            (reset),
        .instr_addr       (instr_addr),
        .data_addr        (data_addr),
        .should_read_mem  (should_read_mem),
        .should_write_mem (should_write_mem),
        .mem_write_data   (mem_write_data),
        .instr            (instr),
        .mem_read_data    (mem_read_data),
        .core_stall       (core_stall),
        .bus_err          (bus_err),
        .instret          (instret),
        .mem              (mif.master)
    );

    // Memory model: acks after a programmable number of wait cycles.
    logic        ack_en = 1'b1;
    logic        force_ack = 1'b0;
    logic [31:0] fetch_word = ALU;
    logic [31:0] load_word = 32'h0;
    int          fetch_wait = 0;
    int          data_wait = 0;
    logic [7:0]  rc = 8'd0;
    logic        is_fetch;

    assign is_fetch = (mif.mem_addr == instr_addr);
    assign mif.mem_ack = force_ack | (ack_en & mif.mem_req &
        (int'(rc) == (is_fetch ? fetch_wait : data_wait)));
    assign mif.mem_rdata = is_fetch ? fetch_word : load_word;

    always @(posedge clk) begin
        if (!mif.mem_req || mif.mem_ack) rc <= 8'd0;
        else rc <= rc + 8'd1;
    end

    int checks = 0;
    int failures = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++; if (instr !== NOP) begin failures++;
            $display("FAIL reset_instr got=%h want=%h", instr, NOP); end
        checks++; if (mem_read_data !== 32'h0) begin failures++;
            $display("FAIL reset_rdata got=%h want=0", mem_read_data); end
        checks++; if (core_stall !== 1'b1) begin failures++;
            $display("FAIL reset_stall got=%b want=1", core_stall); end
        checks++; if (mif.mem_req !== 1'b0) begin failures++;
            $display("FAIL reset_req got=%b want=0", mif.mem_req); end
        checks++; if (mif.mem_we !== 1'b0) begin failures++;
            $display("FAIL reset_we got=%b want=0", mif.mem_we); end
        checks++; if (bus_err !== 1'b0) begin failures++;
            $display("FAIL reset_buserr got=%b want=0", bus_err); end
        checks++; if (instret !== 32'h0) begin failures++;
            $display("FAIL reset_instret got=%0d want=0", instret); end
    endtask

    task automatic test_alu();
        logic [9:0] exp_stall;
        logic [9:0] exp_req;
        exp_stall = 10'b0110110111;
        exp_req   = 10'b0010010010;
        instr_addr = 32'h10; data_addr = 32'h100;
        should_read_mem = 1'b0; should_write_mem = 1'b0;
        fetch_word = ALU; fetch_wait = 0; ack_en = 1'b1;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            checks++; if (core_stall !== exp_stall[c]) begin failures++;
                $display("FAIL alu_stall c=%0d got=%b want=%b", c, core_stall, exp_stall[c]); end
            checks++; if (mif.mem_req !== exp_req[c]) begin failures++;
                $display("FAIL alu_req c=%0d got=%b want=%b", c, mif.mem_req, exp_req[c]); end
            tick();
        end
        checks++; if (instret !== 32'd3) begin failures++;
            $display("FAIL alu_instret got=%0d want=3", instret); end
        checks++; if (instr !== ALU) begin failures++;
            $display("FAIL alu_instr got=%h want=%h", instr, ALU); end
    endtask

    task automatic test_load();
        logic [6:0] exp_stall;
        exp_stall = 7'b0111111;
        instr_addr = 32'h10; data_addr = 32'h100;
        should_read_mem = 1'b1; should_write_mem = 1'b0;
        fetch_word = LW; load_word = 32'hDEADBEEF;
        fetch_wait = 0; data_wait = 2; ack_en = 1'b1;
        do_reset();
        for (int c = 0; c < 7; c++) begin
            checks++; if (core_stall !== exp_stall[c]) begin failures++;
                $display("FAIL load_stall c=%0d got=%b want=%b", c, core_stall, exp_stall[c]); end
            if (c == 3) begin
                checks++; if (mif.mem_req !== 1'b1 || mif.mem_we !== 1'b0) begin failures++;
                    $display("FAIL load_req got=%b/%b want=1/0", mif.mem_req, mif.mem_we); end
                checks++; if (mif.mem_addr !== 32'h100) begin failures++;
                    $display("FAIL load_addr got=%h want=00000100", mif.mem_addr); end
            end
            if (c == 5) begin
                checks++; if (mem_read_data !== 32'h0) begin failures++;
                    $display("FAIL load_early got=%h want=0", mem_read_data); end
            end
            if (c < 6) tick();
        end
        checks++; if (mem_read_data !== 32'hDEADBEEF) begin failures++;
            $display("FAIL load_rdata got=%h want=deadbeef", mem_read_data); end
        checks++; if (instr !== LW) begin failures++;
            $display("FAIL load_instr got=%h want=%h", instr, LW); end
    endtask

    // Continues straight from the load's COMMIT cycle (cycle 6).
    task automatic test_store();
        int wr_cnt;
        wr_cnt = 0;
        should_read_mem = 1'b0; should_write_mem = 1'b1;
        data_addr = 32'h200; mem_write_data = 32'h12345678;
        fetch_word = SW; data_wait = 0;
        for (int c = 7; c < 12; c++) begin
            tick();
            if (mif.mem_req === 1'b1 && mif.mem_we === 1'b1) wr_cnt++;
            if (c == 9) begin
                checks++; if (mif.mem_req !== 1'b1 || mif.mem_we !== 1'b1) begin failures++;
                    $display("FAIL store_req got=%b/%b want=1/1", mif.mem_req, mif.mem_we); end
                checks++; if (mif.mem_addr !== 32'h200) begin failures++;
                    $display("FAIL store_addr got=%h want=00000200", mif.mem_addr); end
                checks++; if (mif.mem_wdata !== 32'h12345678) begin failures++;
                    $display("FAIL store_wdata got=%h want=12345678", mif.mem_wdata); end
            end
            if (c == 10) begin
                checks++; if (core_stall !== 1'b0) begin failures++;
                    $display("FAIL store_commit got=%b want=0", core_stall); end
                checks++; if (mem_read_data !== 32'hDEADBEEF) begin failures++;
                    $display("FAIL store_rdata got=%h want=deadbeef", mem_read_data); end
            end
        end
        checks++; if (wr_cnt != 1) begin failures++;
            $display("FAIL store_count got=%0d want=1", wr_cnt); end
        checks++; if (instret !== 32'd2) begin failures++;
            $display("FAIL store_instret got=%0d want=2", instret); end
        should_write_mem = 1'b0;
    endtask

    task automatic test_timeout();
        int bad;
        bad = 0;
        instr_addr = 32'h10; data_addr = 32'h100;
        should_read_mem = 1'b0; should_write_mem = 1'b0;
        fetch_word = ALU; fetch_wait = 0; ack_en = 1'b1;
        do_reset();
        tick(); tick(); tick();
        checks++; if (core_stall !== 1'b0) begin failures++;
            $display("FAIL to_commit got=%b want=0", core_stall); end
        ack_en = 1'b0;
        for (int c = 4; c < 8; c++) begin
            tick();
            checks++; if (mif.mem_req !== 1'b1 || bus_err !== 1'b0) begin failures++;
                $display("FAIL to_wait c=%0d req=%b err=%b want=1/0", c, mif.mem_req, bus_err); end
        end
        checks++; if (instr !== ALU) begin failures++;
            $display("FAIL to_instr_pre got=%h want=%h", instr, ALU); end
        tick();
        checks++; if (bus_err !== 1'b1) begin failures++;
            $display("FAIL to_buserr got=%b want=1", bus_err); end
        checks++; if (instr !== NOP) begin failures++;
            $display("FAIL to_instr got=%h want=%h", instr, NOP); end
        checks++; if (mif.mem_req !== 1'b0 || core_stall !== 1'b1) begin failures++;
            $display("FAIL to_halt req=%b stall=%b want=0/1", mif.mem_req, core_stall); end
        ack_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (mif.mem_req !== 1'b0 || core_stall !== 1'b1) bad++;
        end
        checks++; if (bad != 0) begin failures++;
            $display("FAIL to_stuck got=%0d bad cycles want=0", bad); end
        checks++; if (bus_err !== 1'b1 || instret !== 32'd1) begin failures++;
            $display("FAIL to_final err=%b instret=%0d want=1/1", bus_err, instret); end
    endtask

    task automatic test_both();
        instr_addr = 32'h10; data_addr = 32'h200;
        should_read_mem = 1'b1; should_write_mem = 1'b1;
        mem_write_data = 32'hA5A5A5A5; load_word = 32'h5555AAAA;
        fetch_word = ALU; fetch_wait = 0; data_wait = 0; ack_en = 1'b1;
        do_reset();
        tick(); tick();
        checks++; if (bus_err !== 1'b0) begin failures++;
            $display("FAIL both_early got=%b want=0", bus_err); end
        tick();
        checks++; if (mif.mem_req !== 1'b1 || mif.mem_we !== 1'b1) begin failures++;
            $display("FAIL both_write got=%b/%b want=1/1", mif.mem_req, mif.mem_we); end
        checks++; if (bus_err !== 1'b1) begin failures++;
            $display("FAIL both_buserr got=%b want=1", bus_err); end
        tick();
        checks++; if (core_stall !== 1'b0) begin failures++;
            $display("FAIL both_commit got=%b want=0", core_stall); end
        checks++; if (mem_read_data !== 32'h0) begin failures++;
            $display("FAIL both_rdata got=%h want=0", mem_read_data); end
        tick();
        checks++; if (instret !== 32'd1) begin failures++;
            $display("FAIL both_instret got=%0d want=1", instret); end
        should_read_mem = 1'b0; should_write_mem = 1'b0;
    endtask

    task automatic test_reset_mid();
        instr_addr = 32'h10; data_addr = 32'h100;
        should_read_mem = 1'b1; should_write_mem = 1'b0;
        fetch_word = LW; load_word = 32'hCAFEF00D;
        fetch_wait = 0; data_wait = 10; ack_en = 1'b1;
        do_reset();
        tick(); tick(); tick();
        checks++; if (mif.mem_req !== 1'b1 || mif.mem_addr !== 32'h100) begin failures++;
            $display("FAIL mid_data req=%b addr=%h want=1/00000100", mif.mem_req, mif.mem_addr); end
        tick();
        reset = 1'b1;
        tick();
        checks++; if (mif.mem_req !== 1'b0) begin failures++;
            $display("FAIL mid_drop got=%b want=0", mif.mem_req); end
        reset = 1'b0;
        force_ack = 1'b1;
        fetch_word = 32'hBAD0BAD0;
        tick();
        force_ack = 1'b0;
        checks++; if (mif.mem_req !== 1'b1 || core_stall !== 1'b1) begin failures++;
            $display("FAIL mid_fetch req=%b stall=%b want=1/1", mif.mem_req, core_stall); end
        checks++; if (instr !== NOP) begin failures++;
            $display("FAIL mid_instr got=%h want=%h", instr, NOP); end
        checks++; if (mem_read_data !== 32'h0 || instret !== 32'h0) begin failures++;
            $display("FAIL mid_state rdata=%h instret=%0d want=0/0", mem_read_data, instret); end
        fetch_word = LW;
        tick();
        checks++; if (instr !== LW) begin failures++;
            $display("FAIL mid_restart got=%h want=%h", instr, LW); end
        should_read_mem = 1'b0;
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_timeout();
        test_both();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
